// File: rtl/pri_scan_if.sv
// ---------------------------------------------------------------------------
// pri_scan_if
// Handshake bundle for pri_scan_encoder.
//   in_valid / in_ready / in_vec    : request vector accepted from upstream
//   out_valid / out_ready           : per-index beat handshake to downstream
//   out_idx                         : index of the current pending bit
//   out_last                        : final beat for the accepted vector
//   out_empty                       : accepted vector was all-zero
//   out_remain (PRI_SCAN_REMAIN_EN) : set bits still pending, current included
// Modports: slave = encoder side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface pri_scan_if #(
    parameter int WIDTH = 56,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_empty;
`ifdef PRI_SCAN_REMAIN_EN
    logic [IDX_W:0]   out_remain;

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_empty, out_remain
    );

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_empty, out_remain
    );
`else
    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_empty
    );

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_empty
    );
`endif
endinterface

// File: rtl/pri_scan_encoder.sv
// ---------------------------------------------------------------------------
// pri_scan_encoder
// Registers a WIDTH-bit request vector and streams the index of every set
// bit, one per output beat, in priority order (MSB first when MSB_FIRST=1,
// LSB first otherwise). Each emitted bit is cleared from the pending copy.
// An all-zero vector produces a single beat flagged out_empty.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : pri_scan_if.slave (in_valid/in_ready/in_vec,
//            out_valid/out_ready/out_idx/out_last/out_empty[/out_remain])
//
// Optional feature macro: PRI_SCAN_REMAIN_EN
//   When defined, bus.out_remain reports how many set bits are still to be
//   emitted (current beat included), from a down-counter loaded at accept.
// ---------------------------------------------------------------------------
module pri_scan_encoder #(
    parameter int  WIDTH     = 56,
    parameter int  MSB_FIRST = 1,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    pri_scan_if.slave bus
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    // Encoder tree works on a power-of-two leaf count; extra leaves are zero.
    localparam int P = 1 << IDX_W;

    logic [0:0]       state_r;
    logic [WIDTH-1:0] pending_r;
    logic             zero_r;

    logic [P-1:0]     leaf_s;
    logic             root_v_s;
    logic [IDX_W-1:0] enc_idx_s;
    logic             one_left_s;
    logic [WIDTH-1:0] clear_mask_s;

    logic             out_valid_s;
    logic             out_last_s;
    logic             out_empty_s;
    logic [IDX_W-1:0] out_idx_s;
    logic             out_fire_s;
    logic             in_ready_s;
    logic             load_s;

    // Zero-pad pending onto the tree leaves so unused leaves never carry X.
    always_comb begin
        leaf_s                = {P{1'b0}};
        leaf_s[WIDTH-1:0]     = pending_r;
    end

    // Log2-depth priority tree: each node merges two children, keeps the
    // winning child's index and sets bit 'lv' when the upper child wins.
    genvar lv, nd;
    for (lv = 0; lv < IDX_W; lv++) begin : g_lvl
        localparam int N = P >> (lv + 1);
        logic [2*N-1:0]       cv_s;
        logic [2*N*IDX_W-1:0] ci_s;
        logic [N-1:0]         v_s;
        logic [N*IDX_W-1:0]   i_s;

        if (lv == 0) begin : g_leaf
            assign cv_s = leaf_s;
            assign ci_s = {(2*N*IDX_W){1'b0}};
        end else begin : g_inner
            assign cv_s = g_lvl[lv-1].v_s;
            assign ci_s = g_lvl[lv-1].i_s;
        end

        for (nd = 0; nd < N; nd++) begin : g_node
            logic pick_hi_s;
            assign pick_hi_s = (MSB_FIRST != 0) ? cv_s[2*nd+1] : !cv_s[2*nd];
            assign v_s[nd]   = cv_s[2*nd] | cv_s[2*nd+1];
            assign i_s[nd*IDX_W +: IDX_W] = pick_hi_s
                ? (ci_s[(2*nd+1)*IDX_W +: IDX_W] | (IDX_W'(1) << lv))
                : ci_s[(2*nd)*IDX_W +: IDX_W];
        end
    end

    assign root_v_s  = g_lvl[IDX_W-1].v_s[0];
    assign enc_idx_s = g_lvl[IDX_W-1].i_s[IDX_W-1:0];

    // Clearing the lowest set bit leaves zero iff at most one bit is set.
    assign one_left_s   = ((pending_r & (pending_r - WIDTH'(1))) == {WIDTH{1'b0}});
    assign clear_mask_s = WIDTH'(1) << out_idx_s;

    // Output view and handshake qualifiers; outputs read zero while idle.
    always_comb begin
        out_valid_s = (state_r == ST_SCAN);
        out_empty_s = out_valid_s & zero_r;
        out_last_s  = out_valid_s & (zero_r | one_left_s);
        if (out_valid_s && root_v_s) begin
            out_idx_s = enc_idx_s;
        end else begin
            out_idx_s = {IDX_W{1'b0}};
        end
        out_fire_s  = out_valid_s & bus.out_ready;
        // A new vector may also enter on the final beat, avoiding a bubble.
        in_ready_s  = ~out_valid_s | (out_fire_s & out_last_s);
        load_s      = bus.in_valid & in_ready_s;
    end

    // FSM, pending vector and empty-flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            pending_r <= {WIDTH{1'b0}};
            zero_r    <= 1'b0;
        end else if (load_s) begin
            state_r   <= ST_SCAN;
            pending_r <= bus.in_vec;
            zero_r    <= (bus.in_vec == {WIDTH{1'b0}});
        end else if (out_fire_s) begin
            pending_r <= pending_r & ~clear_mask_s;
            if (out_last_s) begin
                state_r <= ST_IDLE;
            end else begin
                state_r <= ST_SCAN;
            end
        end
    end

    assign bus.out_valid = out_valid_s;
    assign bus.in_ready  = in_ready_s;
    assign bus.out_idx   = out_idx_s;
    assign bus.out_last  = out_last_s;
    assign bus.out_empty = out_empty_s;

`ifdef PRI_SCAN_REMAIN_EN
    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] c;
        c = {(IDX_W+1){1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{IDX_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [IDX_W:0] remain_r;

    // Remaining-bit counter: loaded at accept, stepped down per emitted bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remain_r <= {(IDX_W+1){1'b0}};
        end else if (load_s) begin
            remain_r <= popcount(bus.in_vec);
        end else if (out_fire_s && (remain_r != {(IDX_W+1){1'b0}})) begin
            remain_r <= remain_r - {{IDX_W{1'b0}}, 1'b1};
        end
    end

    assign bus.out_remain = remain_r;
`endif

endmodule

// File: tb/tb_pri_scan_encoder.sv
module tb_pri_scan_encoder;
    localparam int WIDTH = 56;
    localparam int IDX_W = $clog2(WIDTH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] in_vec;

    int tests = 0;
    int fails = 0;

    // Two encoders driven in lockstep: index 0 = MSB first, 1 = LSB first.
    pri_scan_if #(.WIDTH(WIDTH)) if_m ();
    pri_scan_if #(.WIDTH(WIDTH)) if_l ();

    assign if_m.in_valid  = in_valid;
    assign if_m.in_vec    = in_vec;
    assign if_m.out_ready = out_ready;
    assign if_l.in_valid  = in_valid;
    assign if_l.in_vec    = in_vec;
    assign if_l.out_ready = out_ready;

    pri_scan_encoder #(.WIDTH(WIDTH), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .bus(if_m)
    );
    pri_scan_encoder #(.WIDTH(WIDTH), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .bus(if_l)
    );

    logic             ov [2];
    logic             ir [2];
    logic             ol [2];
    logic             oe [2];
    logic [IDX_W-1:0] oi [2];
    assign ov[0] = if_m.out_valid; assign ov[1] = if_l.out_valid;
    assign ir[0] = if_m.in_ready;  assign ir[1] = if_l.in_ready;
    assign ol[0] = if_m.out_last;  assign ol[1] = if_l.out_last;
    assign oe[0] = if_m.out_empty; assign oe[1] = if_l.out_empty;
    assign oi[0] = if_m.out_idx;   assign oi[1] = if_l.out_idx;
`ifdef PRI_SCAN_REMAIN_EN
    logic [IDX_W:0] orem [2];
    assign orem[0] = if_m.out_remain;
    assign orem[1] = if_l.out_remain;
`endif

    // Reference model: a queue of indices still to be emitted per encoder.
    bit busy  = 1'b0;
    bit zflag = 1'b0;
    int mq  [2][$];
    int obs [2][$];

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    task automatic load_model(logic [WIDTH-1:0] v);
        zflag = (v == '0);
        for (int d = 0; d < 2; d++) begin
            mq[d].delete();
            if (zflag) mq[d].push_back(0);
            else begin
                for (int i = 0; i < WIDTH; i++) begin
                    int b;
                    b = (d == 0) ? (WIDTH - 1 - i) : i;
                    if (v[b]) mq[d].push_back(b);
                end
            end
        end
        busy = 1'b1;
    endtask

    // Called at a falling edge with inputs set: compare, advance model, step.
    task automatic cycle();
        bit exp_last;
        bit exp_ir;
        #1;
        exp_last = busy && (mq[0].size() == 1);
        exp_ir   = !busy || (out_ready && exp_last);
        for (int d = 0; d < 2; d++) begin
            chk("in_ready", d, 32'(ir[d]), 32'(exp_ir));
            chk("out_valid", d, 32'(ov[d]), 32'(busy));
            if (busy) begin
                chk("out_idx", d, 32'(oi[d]), mq[d][0]);
                chk("out_last", d, 32'(ol[d]), 32'(mq[d].size() == 1));
                chk("out_empty", d, 32'(oe[d]), 32'(zflag));
`ifdef PRI_SCAN_REMAIN_EN
                chk("out_remain", d, 32'(orem[d]), zflag ? 0 : mq[d].size());
`endif
                if (out_ready && rst_n) obs[d].push_back(int'(oi[d]));
            end else begin
                chk("idle_idx", d, 32'(oi[d]), 0);
                chk("idle_last", d, 32'(ol[d]), 0);
                chk("idle_empty", d, 32'(oe[d]), 0);
`ifdef PRI_SCAN_REMAIN_EN
                chk("idle_remain", d, 32'(orem[d]), 0);
`endif
            end
        end
        if (!rst_n) begin
            busy = 1'b0;
            mq[0].delete();
            mq[1].delete();
        end else begin
            if (busy && out_ready) begin
                void'(mq[0].pop_front());
                void'(mq[1].pop_front());
                if (mq[0].size() == 0) busy = 1'b0;
            end
            if (in_valid && exp_ir) load_model(in_vec);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(bit iv, logic [WIDTH-1:0] v, bit rdy);
        in_valid  = iv;
        in_vec    = v;
        out_ready = rdy;
        cycle();
    endtask

    task automatic clear_obs();
        obs[0].delete();
        obs[1].delete();
    endtask

    logic [WIDTH-1:0] vec;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
        @(negedge clk);
        drive(0, '0, 0);
        drive(0, '0, 1);
        rst_n = 1'b1;
        drive(0, '0, 1);

        // 55 set bits, full throughput.
        clear_obs();
        vec = {1'b0, {55{1'b1}}};
        drive(1, vec, 1);
        for (int i = 0; i < 57; i++) drive(0, '0, 1);
        chk("ones_count", 0, obs[0].size(), 55);
        chk("ones_first", 0, obs[0][0], 54);
        chk("ones_final", 0, obs[0][54], 0);
        chk("ones_count", 1, obs[1].size(), 55);
        chk("ones_first", 1, obs[1][0], 0);
        chk("ones_final", 1, obs[1][54], 54);

        // Sparse vector {55,4,0}.
        clear_obs();
        drive(1, 56'h80000000000011, 1);
        for (int i = 0; i < 4; i++) drive(0, '0, 1);
        chk("sparse_count", 1, obs[1].size(), 3);
        chk("sparse_b0", 1, obs[1][0], 0);
        chk("sparse_b1", 1, obs[1][1], 4);
        chk("sparse_b2", 1, obs[1][2], 55);
        chk("sparse_b0", 0, obs[0][0], 55);

        // Empty vector: exactly one beat, then idle.
        clear_obs();
        drive(1, '0, 1);
        chk("empty_flag", 0, 32'(oe[0]), 1);
        chk("empty_last", 0, 32'(ol[0]), 1);
        drive(0, '0, 1);
        drive(0, '0, 1);
        chk("empty_count", 0, obs[0].size(), 1);
        chk("empty_ready", 0, 32'(ir[0]), 1);

        // Backpressure on {10,3}.
        clear_obs();
        drive(1, (WIDTH'(1) << 10) | (WIDTH'(1) << 3), 1);
        drive(0, '0, 0);
        drive(0, '0, 0);
        drive(0, '0, 1);
        drive(0, '0, 0);
        drive(0, '0, 1);
        drive(0, '0, 1);
        chk("bp_count", 0, obs[0].size(), 2);
        chk("bp_b0", 0, obs[0][0], 10);
        chk("bp_b1", 0, obs[0][1], 3);

        // Back-to-back {7} then {2,1}.
        clear_obs();
        drive(1, WIDTH'(1) << 7, 1);
        drive(1, (WIDTH'(1) << 2) | (WIDTH'(1) << 1), 1);
        drive(0, '0, 1);
        drive(0, '0, 1);
        drive(0, '0, 1);
        chk("b2b_count", 0, obs[0].size(), 3);
        chk("b2b_b1", 0, obs[0][1], 2);
        chk("b2b_b2", 0, obs[0][2], 1);
        chk("b2b_b1", 1, obs[1][1], 1);

        // Reset in the middle of {40,20,5}, then rescan the same vector.
        vec = (WIDTH'(1) << 40) | (WIDTH'(1) << 20) | (WIDTH'(1) << 5);
        drive(1, vec, 1);
        drive(0, '0, 1);
        rst_n = 1'b0;
        drive(0, '0, 1);
        rst_n = 1'b1;
        chk("rst_valid", 0, 32'(ov[0]), 0);
        chk("rst_ready", 0, 32'(ir[0]), 1);
`ifdef PRI_SCAN_REMAIN_EN
        chk("rst_remain", 0, 32'(orem[0]), 0);
`endif
        drive(1, vec, 1);
`ifdef PRI_SCAN_REMAIN_EN
        chk("rescan_remain", 0, 32'(orem[0]), 3);
`endif
        chk("rescan_idx", 0, 32'(oi[0]), 40);
        for (int i = 0; i < 4; i++) drive(0, '0, 1);

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int mode;
            rst_n     = ($urandom_range(0, 79) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 3);
            vec = '0;
            if (mode == 1) begin
                vec = WIDTH'({$urandom, $urandom});
            end else if (mode >= 2) begin
                for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                    vec[$urandom_range(0, WIDTH - 1)] = 1'b1;
            end
            in_vec = vec;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
